// File: rtl/key_evt_pkg.sv
// Shared state encoding, default timing limits and a small helper for key_evt.
// The optional double-press path is enabled with KEY_EVT_DBL_EN.
package key_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS  = 3'd1,
        ST_LONG   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4
    } key_state_e;

    localparam int LONG_T_DEF = 500;
    localparam int GAP_T_DEF  = 150;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_evt_cnt.sv
// Sample counter for key_evt: advances on ce when asked, clears synchronously,
// and flags when the current count equals the terminal value.
module key_evt_cnt #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] term,
    output logic          hit
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (ce && inc)
            cnt <= cnt + CW'(1);
    end

    assign hit = (cnt == term);

endmodule

// File: rtl/key_evt.sv
// Press-event classifier: turns each filtered press into one short/long/double pulse.
// Define KEY_EVT_DBL_EN to build the double-press path (GAP and PRESS2 states).
module key_evt
    import key_evt_pkg::*;
#(
    parameter int LONG_T = LONG_T_DEF,
    parameter int GAP_T  = GAP_T_DEF,
    parameter int CW     = $clog2(max2(LONG_T, GAP_T))
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic lvl,
    output logic short_p,
    output logic long_p,
    output logic dbl_p,
    output logic held,
    output logic busy
);

    logic [2:0]    state, nxt;
    logic          hit, inc, clr;
    logic [CW-1:0] term;
    logic          fire_short, fire_long;
`ifdef KEY_EVT_DBL_EN
    logic          fire_dbl;
`endif

    // Counter is compared before it increments, so the terminal is limit-2:
    // the sample that would make the count limit-1 is the deciding one.
`ifdef KEY_EVT_DBL_EN
    assign term = (state == ST_GAP) ? CW'(GAP_T - 2) : CW'(LONG_T - 2);
    assign inc  = ((state == ST_PRESS || state == ST_PRESS2) && lvl)
                || (state == ST_GAP && !lvl);
`else
    assign term = CW'(LONG_T - 2);
    assign inc  = (state == ST_PRESS) && lvl;
`endif
    assign clr = (nxt != state);

    key_evt_cnt #(.CW(CW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .clr  (clr),
        .inc  (inc),
        .term (term),
        .hit  (hit)
    );

    always_comb begin
        nxt        = state;
        fire_short = 1'b0;
        fire_long  = 1'b0;
`ifdef KEY_EVT_DBL_EN
        fire_dbl   = 1'b0;
`endif
        case (state)
            ST_IDLE: if (ce && lvl) nxt = ST_PRESS;
            ST_PRESS: begin
                if (ce) begin
                    if (lvl) begin
                        if (hit) begin
                            nxt       = ST_LONG;
                            fire_long = 1'b1;
                        end
                    end else begin
`ifdef KEY_EVT_DBL_EN
                        nxt = ST_GAP;
`else
                        nxt        = ST_IDLE;
                        fire_short = 1'b1;
`endif
                    end
                end
            end
            ST_LONG: if (ce && !lvl) nxt = ST_IDLE;
`ifdef KEY_EVT_DBL_EN
            ST_GAP: begin
                if (ce) begin
                    if (lvl) begin
                        nxt = ST_PRESS2;
                    end else if (hit) begin
                        nxt        = ST_IDLE;
                        fire_short = 1'b1;
                    end
                end
            end
            ST_PRESS2: begin
                if (ce) begin
                    if (!lvl) begin
                        nxt      = ST_IDLE;
                        fire_dbl = 1'b1;
                    end else if (hit) begin
                        nxt      = ST_LONG;
                        fire_dbl = 1'b1;
                    end
                end
            end
`endif
            // Unused encodings recover silently, regardless of ce.
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            short_p <= 1'b0;
            long_p  <= 1'b0;
            held    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= nxt;
            short_p <= fire_short;
            long_p  <= fire_long;
            held    <= (nxt == ST_LONG);
            busy    <= (nxt != ST_IDLE);
        end
    end

`ifdef KEY_EVT_DBL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dbl_p <= 1'b0;
        else
            dbl_p <= fire_dbl;
    end
`else
    assign dbl_p = 1'b0;
`endif

endmodule
